// File: rtl/sbqm_pkg.sv
// Shared types and constants for the bank-queue occupancy controller.
// The wait-time function is only ever evaluated at elaboration to fill a lookup table.
package sbqm_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        ACTIVE = 2'b01,
        FULL   = 2'b10
    } sbqmState_t;

    localparam int DEF_MAX_COUNT    = 7;
    localparam int DEF_SERVICE_TIME = 3;

    // A teller count of 0 is treated as 1; an empty queue always means no wait.
    function automatic int waitMinutes(input int count, input int tellers, input int serviceTime);
        int t;
        t = (tellers < 1) ? 1 : tellers;
        if (count == 0)
            return 0;
        return (serviceTime * (count + t - 1)) / t;
    endfunction

endpackage

// File: rtl/sbqm_pulse_sync.sv
// Synchronizes an active-low photocell pulse into clk and emits one single-cycle
// event per 1->0 transition of the synchronized level.
module sbqm_pulse_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pulseIn,
    output logic fallEvent
);

    logic [SYNC_STAGES-1:0] syncReg;
    logic                   prevReg;
    logic [SYNC_STAGES:0]   armReg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            syncReg[0] <= 1'b1;
        else
            syncReg[0] <= pulseIn;
    end

    genvar gi;
    generate
        for (gi = 1; gi < SYNC_STAGES; gi++) begin : gStage
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    syncReg[gi] <= 1'b1;
                else
                    syncReg[gi] <= syncReg[gi-1];
            end
        end
    endgenerate

    // The arm chain holds off detection until the reset-value ones have flushed out,
    // so a pulse that was already low when reset released is discarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prevReg <= 1'b1;
            armReg  <= '0;
        end else begin
            prevReg <= syncReg[SYNC_STAGES-1];
            armReg  <= {armReg[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign fallEvent = armReg[SYNC_STAGES] & prevReg & ~syncReg[SYNC_STAGES-1];

endmodule

// File: rtl/sbqm_queue_controller.sv
// Bank-queue occupancy controller: entry/exit event arbitration, bounded customer
// count with full/empty/reject flags, and a table-driven estimated wait time.
module sbqm_queue_controller
    import sbqm_pkg::*;
#(
    parameter int COUNT_W      = 3,
    parameter int MAX_COUNT    = DEF_MAX_COUNT,
    parameter int SERVICE_TIME = DEF_SERVICE_TIME,
    parameter int WAIT_W       = 5,
    parameter int SYNC_STAGES  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               upSignal,
    input  logic               downSignal,
    input  logic [1:0]         tellerCount,
    output logic [COUNT_W-1:0] stateOutput,
    output logic [WAIT_W-1:0]  waitTime,
    output logic               fullFlag,
    output logic               emptyFlag,
    output logic               rejectFlag
);

    localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(MAX_COUNT);
    localparam int                 LUT_ROWS = 2 ** COUNT_W;

    logic enterEvent;
    logic exitEvent;

    sbqm_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) uEntrySync (
        .clk       (clk),
        .reset     (reset),
        .pulseIn   (upSignal),
        .fallEvent (enterEvent)
    );

    sbqm_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) uExitSync (
        .clk       (clk),
        .reset     (reset),
        .pulseIn   (downSignal),
        .fallEvent (exitEvent)
    );

    sbqmState_t         stateReg, stateNext;
    logic [COUNT_W-1:0] countReg, countNext;
    logic               rejectReg, rejectNext;
    logic [WAIT_W-1:0]  waitReg;

    // Wait-time table indexed by [count][raw tellerCount], filled at elaboration.
    logic [WAIT_W-1:0] waitLut [LUT_ROWS][4];

    genvar gi, gj;
    generate
        for (gi = 0; gi < LUT_ROWS; gi++) begin : gLutRow
            for (gj = 0; gj < 4; gj++) begin : gLutCol
                localparam int MINUTES = waitMinutes(gi, gj, SERVICE_TIME);
                assign waitLut[gi][gj] = WAIT_W'(MINUTES);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg  <= EMPTY;
            countReg  <= '0;
            rejectReg <= 1'b0;
            waitReg   <= '0;
        end else begin
            stateReg  <= stateNext;
            countReg  <= countNext;
            rejectReg <= rejectNext;
            waitReg   <= waitLut[countReg][tellerCount];
        end
    end

    // Simultaneous entry and exit is a swap: nothing changes and nothing is rejected.
    always_comb begin
        stateNext  = stateReg;
        countNext  = countReg;
        rejectNext = 1'b0;
        if (enterEvent && !exitEvent) begin
            case (stateReg)
                FULL: rejectNext = 1'b1;
                default: begin
                    countNext = countReg + 1'b1;
                    stateNext = ((countReg + 1'b1) == MAX_CNT) ? FULL : ACTIVE;
                end
            endcase
        end else if (exitEvent && !enterEvent) begin
            case (stateReg)
                EMPTY: rejectNext = 1'b1;
                default: begin
                    countNext = countReg - 1'b1;
                    stateNext = (countReg == COUNT_W'(1)) ? EMPTY : ACTIVE;
                end
            endcase
        end
    end

    always_comb begin
        fullFlag  = (stateReg == FULL);
        emptyFlag = (stateReg == EMPTY);
    end

    assign stateOutput = countReg;
    assign waitTime    = waitReg;
    assign rejectFlag  = rejectReg;

endmodule

// File: tb/tb_sbqm_queue_controller.sv
// Directed bench for sbqm_queue_controller: fill/drain, teller changes, swaps, reset mid-pulse.
module tb_sbqm_queue_controller;

    logic       clk;
    logic       reset;
    logic       upSignal;
    logic       downSignal;
    logic [1:0] tellerCount;
    logic [2:0] stateOutput;
    logic [4:0] waitTime;
    logic       fullFlag;
    logic       emptyFlag;
    logic       rejectFlag;

    int total = 0;
    int bad   = 0;

    sbqm_queue_controller dut (
        .clk         (clk),
        .reset       (reset),
        .upSignal    (upSignal),
        .downSignal  (downSignal),
        .tellerCount (tellerCount),
        .stateOutput (stateOutput),
        .waitTime    (waitTime),
        .fullFlag    (fullFlag),
        .emptyFlag   (emptyFlag),
        .rejectFlag  (rejectFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives a 5-low/5-high pulse on the selected inputs; reports the count two and
    // three edges after the first low sample, and how many cycles rejectFlag was high.
    task automatic doPulse(input bit onUp, input bit onDown,
                           output int cnt2, output int cnt3, output int rejCycles);
        rejCycles = 0;
        cnt2 = 0;
        cnt3 = 0;
        @(negedge clk);
        if (onUp)   upSignal   = 1'b0;
        if (onDown) downSignal = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 2) cnt2 = int'(stateOutput);
            if (i == 3) cnt3 = int'(stateOutput);
            rejCycles += int'(rejectFlag);
            if (i == 5) begin
                upSignal   = 1'b1;
                downSignal = 1'b1;
            end
        end
    endtask

    initial begin
        int c2, c3, rj, expCnt, prevCnt;
        upSignal    = 1'b1;
        downSignal  = 1'b1;
        tellerCount = 2'd1;
        reset       = 1'b0;

        repeat (10) @(negedge clk);
        check("rst_count", int'(stateOutput), 0);
        check("rst_empty", int'(emptyFlag), 1);
        check("rst_full", int'(fullFlag), 0);
        check("rst_wait", int'(waitTime), 0);
        check("rst_reject", int'(rejectFlag), 0);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_count", int'(stateOutput), 0);
        check("post_rst_reject", int'(rejectFlag), 0);
        $display("reset released: count=%0d empty=%0d wait=%0d", stateOutput, emptyFlag, waitTime);

        // Fill: 9 entries, the last two rejected.
        for (int k = 1; k <= 9; k++) begin
            prevCnt = (k - 1 > 7) ? 7 : k - 1;
            expCnt  = (k > 7) ? 7 : k;
            doPulse(1'b1, 1'b0, c2, c3, rj);
            check("up_latency_pre", c2, prevCnt);
            check("up_latency_edge3", c3, expCnt);
            check("up_reject", rj, (k > 7) ? 1 : 0);
            check("up_full", int'(fullFlag), (k >= 7) ? 1 : 0);
            check("up_wait", int'(waitTime), 3 * expCnt);
            $display("up pulse %0d: count=%0d full=%0d rejCycles=%0d wait=%0d", k, stateOutput, fullFlag, rj, waitTime);
        end
        check("fill_wait21", int'(waitTime), 21);
        check("fill_empty", int'(emptyFlag), 0);

        // Drain: 9 exits, the last two rejected.
        for (int k = 1; k <= 9; k++) begin
            expCnt = (7 - k < 0) ? 0 : 7 - k;
            doPulse(1'b0, 1'b1, c2, c3, rj);
            check("down_count", c3, expCnt);
            check("down_reject", rj, (k > 7) ? 1 : 0);
            check("down_empty", int'(emptyFlag), (k >= 7) ? 1 : 0);
            check("down_full", int'(fullFlag), 0);
            check("down_wait", int'(waitTime), 3 * expCnt);
            $display("down pulse %0d: count=%0d empty=%0d rejCycles=%0d wait=%0d", k, stateOutput, emptyFlag, rj, waitTime);
        end

        // Teller sweep at count 4.
        for (int k = 0; k < 4; k++) doPulse(1'b1, 1'b0, c2, c3, rj);
        check("tel_base_count", int'(stateOutput), 4);
        @(negedge clk); tellerCount = 2'd1; repeat (2) @(negedge clk);
        check("tel1_wait", int'(waitTime), 12);
        @(negedge clk); tellerCount = 2'd2; repeat (2) @(negedge clk);
        check("tel2_wait", int'(waitTime), 7);
        @(negedge clk); tellerCount = 2'd3; repeat (2) @(negedge clk);
        check("tel3_wait", int'(waitTime), 6);
        @(negedge clk); tellerCount = 2'd0; repeat (2) @(negedge clk);
        check("tel0_wait", int'(waitTime), 12);
        check("tel_count_kept", int'(stateOutput), 4);
        $display("teller sweep done: count=%0d wait=%0d", stateOutput, waitTime);
        tellerCount = 2'd1;

        // Simultaneous entry/exit at count 3, 7 and 0.
        doPulse(1'b0, 1'b1, c2, c3, rj);
        doPulse(1'b1, 1'b1, c2, c3, rj);
        check("swap3_count", int'(stateOutput), 3);
        check("swap3_reject", rj, 0);
        $display("swap at 3: count=%0d rejCycles=%0d", stateOutput, rj);
        for (int k = 0; k < 4; k++) doPulse(1'b1, 1'b0, c2, c3, rj);
        doPulse(1'b1, 1'b1, c2, c3, rj);
        check("swap7_count", int'(stateOutput), 7);
        check("swap7_reject", rj, 0);
        check("swap7_full", int'(fullFlag), 1);
        $display("swap at 7: count=%0d rejCycles=%0d", stateOutput, rj);
        for (int k = 0; k < 7; k++) doPulse(1'b0, 1'b1, c2, c3, rj);
        doPulse(1'b1, 1'b1, c2, c3, rj);
        check("swap0_count", int'(stateOutput), 0);
        check("swap0_reject", rj, 0);
        check("swap0_empty", int'(emptyFlag), 1);
        $display("swap at 0: count=%0d rejCycles=%0d", stateOutput, rj);

        // Reset one cycle into an entry pulse at count 5.
        for (int k = 0; k < 5; k++) doPulse(1'b1, 1'b0, c2, c3, rj);
        check("pre_midrst_count", int'(stateOutput), 5);
        @(negedge clk); upSignal = 1'b0;
        @(negedge clk); reset = 1'b0;
        #1;
        check("midrst_immediate", int'(stateOutput), 0);
        check("midrst_wait", int'(waitTime), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        rj = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rj += int'(rejectFlag) + int'(stateOutput);
        end
        check("midrst_no_increment", int'(stateOutput), 0);
        check("midrst_quiet", rj, 0);
        upSignal = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_after_release", int'(stateOutput), 0);
        doPulse(1'b1, 1'b0, c2, c3, rj);
        check("midrst_recover", int'(stateOutput), 1);
        $display("reset mid-pulse: count after recovery pulse=%0d", stateOutput);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
